sync_down_timer: RTL and testbench

// - Synchronous loadable down-counter/timer; the count-down counterpart of the team's free-running up counter.
// - Counts a loaded value down to zero at a prescaled rate and flags terminal count.
// - Start/stop/pause control via a small FSM.
// - Used as a countdown timer or event delay in the same board-level designs.
//

---
 rtl/sync_down_timer.sv | 129 ++++++++++++
 tb/tb_sync_down_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_down_timer.sv
// Loadable prescaled down-counter with a start/stop/pause FSM and a one-cycle terminal-count pulse.
// Optional feature macro: AUTO_RELOAD_EN (periodic reload from the last loaded value instead of stopping in DONE).
module sync_down_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 131072
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    // DIV=1 still needs a 1-bit prescaler register; it simply stays at its only value.
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             tick_s;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    assign tick_s = (presc_q == PRESC_LAST);

    // Next-state logic: load overrides everything, then stop, then start, then the prescaler tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d  = load_val;
            presc_d  = '0;
            state_d  = ST_IDLE;
`ifdef AUTO_RELOAD_EN
            reload_d = load_val;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick_s) begin
                        presc_d = '0;
                        if (count_q == WIDTH'(1)) begin
                            tc_d    = 1'b1;
`ifdef AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = ST_DONE;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    // Prescaler phase is kept, so resuming does not restart the current tick period.
                    if (!stop && start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter, prescaler and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            presc_q  <= '0;
            tc_q     <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            tc_q     <= tc_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: two instances (DIV=1 and DIV=4) share random/directed stimulus
// and are compared every cycle against a behavioural timer model.
module tb_sync_down_timer;

    logic       clk = 1'b0;
    logic       rst, load, start, stop;
    logic [3:0] load_val;
    logic [3:0] count0, count1;
    logic       busy0, busy1, tc0, tc1;

    always #5 clk = ~clk;

    sync_down_timer #(.WIDTH(4), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
        .count(count0), .busy(busy0), .tc(tc0)
    );

    sync_down_timer #(.WIDTH(4), .DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
        .count(count1), .busy(busy1), .tc(tc1)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model view of each timer: a count value, a phase within the divide period, and whether it is
    // counting, paused or finished.
    int m_cnt   [2];
    int m_ph    [2];
    int m_rel   [2];
    bit m_act   [2];
    bit m_pau   [2];
    bit m_done  [2];
    bit m_tc    [2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_step(input int k);
        m_tc[k] = 1'b0;
        if (rst) begin
            m_cnt[k] = 0; m_ph[k] = 0; m_rel[k] = 0;
            m_act[k] = 0; m_pau[k] = 0; m_done[k] = 0;
        end else if (load) begin
            m_cnt[k] = int'(load_val); m_rel[k] = int'(load_val); m_ph[k] = 0;
            m_act[k] = 0; m_pau[k] = 0; m_done[k] = 0;
        end else if (m_act[k] && !m_pau[k]) begin
            if (stop) begin
                m_pau[k] = 1'b1;
            end else if (m_ph[k] == div_of(k) - 1) begin
                m_ph[k] = 0;
                if (m_cnt[k] == 1) begin
                    m_tc[k] = 1'b1;
`ifdef AUTO_RELOAD_EN
                    m_cnt[k] = m_rel[k];
`else
                    m_cnt[k] = 0; m_act[k] = 0; m_done[k] = 1;
`endif
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end else begin
                m_ph[k] = m_ph[k] + 1;
            end
        end else if (m_act[k] && m_pau[k]) begin
            if (!stop && start) m_pau[k] = 1'b0;
        end else if (!m_done[k] && start && m_cnt[k] != 0) begin
            m_act[k] = 1'b1;
            m_ph[k]  = 0;
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.cnt  = 4'(m_cnt[k]);
        e.tc   = m_tc[k];
        e.busy = m_act[k];
        return e;
    endfunction

    // One stimulus cycle: drive inputs, advance both models, queue the expected post-edge outputs.
    task automatic cyc(input bit r, input bit ld, input logic [3:0] lv, input bit st, input bit sp);
        rst = r; load = ld; load_val = lv; start = st; stop = sp;
        model_step(0);
        model_step(1);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    function automatic void check(input int k, input exp_t e, input exp_t a);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL div%0d count/tc/busy at %0t: got %0d/%b/%b expected %0d/%b/%b",
                     div_of(k), $time, a.cnt, a.tc, a.busy, e.cnt, e.tc, e.busy);
        end
    endfunction

    // Monitor: every edge the timers present new outputs; pop one expectation per instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check(0, e, {count0, tc0, busy0});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check(1, e, {count1, tc1, busy1});
            end
        end
    end

    initial begin
        int wait_cycles;
        // Reset and a start with nothing loaded.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Load 3 and run to terminal count, then sit in the end state and try to restart.
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(16);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(3);
        // Load 9, pause for 5 cycles, resume, then stop again later.
        cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(6);
        // Reload mid-run, reset mid-run, load together with start.
        cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(20);
        // Randomised control traffic, biased toward short loads so terminal counts are frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 29) == 0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0);
        end
        wait_cycles = 0;
        while ((q0.size() > 0 || q1.size() > 0) && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
